// File: rtl/e1000_dma_pkg.sv
// Shared types and byte-enable helpers for the e1000 DMA datapath.
// Keep masks are big-endian ordered: bit 3 is byte 0 of the word.
package e1000_dma_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    XFER = 2'd2
  } state_t;

  // Bytes at or after the start offset are kept in the first word.
  function automatic logic [3:0] first_keep(input logic [1:0] addr);
    logic [3:0] k;
    case (addr)
      2'd0:    k = 4'b1111;
      2'd1:    k = 4'b0111;
      2'd2:    k = 4'b0011;
      default: k = 4'b0001;
    endcase
    return k;
  endfunction

  // end_off is (addr+len)&3; zero means the final word is full.
  function automatic logic [3:0] last_keep(input logic [1:0] end_off);
    logic [3:0] k;
    case (end_off)
      2'd0:    k = 4'b1111;
      2'd1:    k = 4'b1000;
      2'd2:    k = 4'b1100;
      default: k = 4'b1110;
    endcase
    return k;
  endfunction

  function automatic logic [3:0] bit_rev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry valid/ready output register; reloads on the same cycle it drains.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
// valid never depends on ready, and held data is stable until accepted.
module axis_reg_slice #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [W-1:0] i_s_data,
  input  logic         i_s_valid,
  output logic         o_s_ready,
  output logic [W-1:0] o_m_data,
  output logic         o_m_valid,
  input  logic         i_m_ready
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_s_ready = !r_valid || i_m_ready;
  assign o_m_valid = r_valid;
  assign o_m_data  = r_data;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_s_valid && o_s_ready) begin
      r_valid <= 1'b1;
      r_data  <= i_s_data;
    end else if (i_m_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_dma_framer.sv
// Frames a raw 32-bit host-memory word stream into an AXI-Stream packet carrying exactly
// the commanded bytes, and primes the downstream realigner with offset/init first.
module axis_dma_framer
  import e1000_dma_pkg::*;
#(
  parameter int    LEN_WIDTH         = 16,
  parameter string OUTPUT_BIG_ENDIAN = "TRUE"
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [1:0]           cmd_addr,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [31:0]          m_tdata,
  output logic [3:0]           m_tkeep,
  output logic                 m_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [1:0]           rl_offset,
  output logic                 rl_init,
  input  logic                 rl_idle,
  output logic                 done,
  output logic [1:0]           dbg_state
);

  localparam bit BIG = (OUTPUT_BIG_ENDIAN == "TRUE");

  state_t               r_state, w_next;
  logic [1:0]           r_addr, r_end_off;
  logic [LEN_WIDTH:0]   r_remaining;
  logic                 r_first, r_zero_done, r_alive;
  logic [LEN_WIDTH:0]   w_span;
  logic                 w_cmd_hs, w_s_hs, w_m_hs, w_last_word;
  logic                 w_sl_s_valid, w_sl_s_ready;
  logic [3:0]           w_keep_be, w_keep;
  logic [36:0]          w_sl_in, w_sl_out;

  assign w_cmd_hs = cmd_valid && cmd_ready;
  assign w_s_hs   = s_tvalid && s_tready;
  assign w_m_hs   = m_tvalid && m_tready;
  assign w_span   = (LEN_WIDTH+1)'(cmd_len) + (LEN_WIDTH+1)'(cmd_addr);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_cmd_hs && (cmd_len != '0)) w_next = INIT;
      INIT:    w_next = XFER;
      XFER:    if (w_m_hs && m_tlast) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_alive keeps cmd_ready low while reset is asserted and for the first cycle out of it.
  always_comb begin
    cmd_ready = 1'b0;
    s_tready  = 1'b0;
    rl_init   = 1'b0;
    done      = r_zero_done;
    case (r_state)
      IDLE: cmd_ready = r_alive && !m_tvalid && rl_idle;
      INIT: rl_init   = 1'b1;
      XFER: begin
        s_tready = w_sl_s_ready && (r_remaining != '0);
        done     = w_m_hs && m_tlast;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_alive     <= 1'b0;
      r_zero_done <= 1'b0;
      r_addr      <= '0;
      r_end_off   <= '0;
      r_remaining <= '0;
      r_first     <= 1'b0;
    end else begin
      r_alive     <= 1'b1;
      r_zero_done <= w_cmd_hs && (cmd_len == '0);
      if (w_cmd_hs) begin
        r_addr      <= cmd_addr;
        r_end_off   <= w_span[1:0];
        // ceil(span/4), wide enough that a maximal span cannot wrap
        r_remaining <= (LEN_WIDTH+1)'(w_span[LEN_WIDTH:2]) + (LEN_WIDTH+1)'(w_span[1:0] != 2'b0);
        r_first     <= 1'b1;
      end else if (w_s_hs) begin
        r_remaining <= r_remaining - 1'b1;
        r_first     <= 1'b0;
      end
    end
  end

  assign w_last_word  = (r_remaining == (LEN_WIDTH+1)'(1));
  assign w_keep_be    = (r_first ? first_keep(r_addr) : 4'b1111)
                      & (w_last_word ? last_keep(r_end_off) : 4'b1111);
  assign w_keep       = BIG ? w_keep_be : bit_rev4(w_keep_be);
  assign w_sl_s_valid = s_tvalid && (r_state == XFER) && (r_remaining != '0);
  assign w_sl_in      = {w_last_word, w_keep, s_tdata};

  axis_reg_slice #(.W(37)) u_out_reg (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .i_s_data  (w_sl_in),
    .i_s_valid (w_sl_s_valid),
    .o_s_ready (w_sl_s_ready),
    .o_m_data  (w_sl_out),
    .o_m_valid (m_tvalid),
    .i_m_ready (m_tready)
  );

  assign {m_tlast, m_tkeep, m_tdata} = w_sl_out;
  assign rl_offset = r_addr;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_axis_dma_framer.sv
// Directed bench for axis_dma_framer: each task drives one scenario and checks it inline.
module tb_axis_dma_framer;

  logic        aclk, aresetn;
  logic [1:0]  cmd_addr;
  logic [15:0] cmd_len;
  logic        cmd_valid, cmd_ready;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast, m_tvalid, m_tready;
  logic [1:0]  rl_offset;
  logic        rl_init, rl_idle, done;
  logic [1:0]  dbg_state;

  int n_checks, n_errors, n_timeout;
  int n_sh, n_init, n_done, n_done_last, n_mv_seen, n_st_seen, n_stall_bad, done_cyc;
  logic [1:0]  init_off;
  logic [31:0] src_words [0:7];
  logic [36:0] got_q[$];
  logic [36:0] exp_q[$];

  axis_dma_framer #(.LEN_WIDTH(16), .OUTPUT_BIG_ENDIAN("TRUE")) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .rl_offset(rl_offset), .rl_init(rl_init), .rl_idle(rl_idle), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_cmd(input logic [1:0] a, input logic [15:0] l);
    int k;
    k = 0;
    cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    @(negedge aclk);
    while (!cmd_ready && k < 50) begin
      @(negedge aclk);
      k++;
    end
    if (!cmd_ready) n_timeout++;
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  // Offers nav source words, m_tready always 1 (pat 0) or toggling 1,0,1,0 (pat 1).
  task automatic run_xfer(input int nav, input int pat, input int max_cyc);
    int idx, cyc, post;
    logic [36:0] held;
    logic held_v;
    idx = 0; cyc = 0; post = -1; held = '0; held_v = 1'b0;
    n_sh = 0; n_init = 0; n_done = 0; n_done_last = 0; n_mv_seen = 0; n_st_seen = 0;
    n_stall_bad = 0; done_cyc = -1; init_off = 2'd0;
    got_q.delete();
    forever begin
      s_tvalid = (idx < nav);
      s_tdata  = (idx < 8) ? src_words[idx] : 32'h0;
      m_tready = (pat == 0) ? 1'b1 : ((cyc % 2) == 0);
      @(negedge aclk);
      if (held_v && ({m_tlast, m_tkeep, m_tdata} !== held)) n_stall_bad++;
      held_v = m_tvalid && !m_tready;
      held   = {m_tlast, m_tkeep, m_tdata};
      if (s_tvalid && s_tready) begin n_sh++; idx++; end
      if (s_tready) n_st_seen++;
      if (m_tvalid) n_mv_seen++;
      if (rl_init) begin n_init++; init_off = rl_offset; end
      if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tkeep, m_tdata});
      if (done) begin
        n_done++;
        if (m_tvalid && m_tready && m_tlast) n_done_last++;
        if (post < 0) begin post = 3; done_cyc = cyc; end
      end
      @(posedge aclk); #1;
      cyc++;
      if (post > 0) post--;
      if (post == 0) break;
      if (cyc >= max_cyc) begin n_timeout++; break; end
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_addr = 2'd0; cmd_len = 16'd0;
    s_tvalid = 1'b0; s_tdata = 32'h0; m_tready = 1'b1; rl_idle = 1'b1;
    repeat (3) @(negedge aclk);
    n_checks++; if ({cmd_ready, s_tready, m_tvalid, m_tlast, rl_init, done} !== 6'b0) begin
      n_errors++; $display("FAIL rst_ctrl: got %b expected 000000", {cmd_ready, s_tready, m_tvalid, m_tlast, rl_init, done}); end
    n_checks++; if ({m_tkeep, rl_offset, dbg_state} !== 8'h00) begin
      n_errors++; $display("FAIL rst_keep_off_state: got %h expected 00", {m_tkeep, rl_offset, dbg_state}); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    n_checks++; if (cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL rst_cmd_ready_after: got %b expected 1", cmd_ready); end
    @(posedge aclk); #1;
  endtask

  task automatic test_basic();
    src_words[0] = 32'h00AABBCC; src_words[1] = 32'hDDEEFF00; src_words[2] = 32'h12345678;
    exp_q.delete();
    exp_q.push_back({1'b0, 4'b0111, 32'h00AABBCC});
    exp_q.push_back({1'b1, 4'b1110, 32'hDDEEFF00});
    send_cmd(2'd1, 16'd6);
    run_xfer(3, 0, 40);
    n_checks++; if (n_timeout !== 0) begin n_errors++; $display("FAIL basic_timeout: got %0d expected 0", n_timeout); end
    n_checks++; if (got_q.size() !== 2) begin n_errors++; $display("FAIL basic_nbeats: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL basic_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (n_init !== 1 || init_off !== 2'd1) begin
      n_errors++; $display("FAIL basic_rl_init: got %0d pulses off %0d expected 1 pulse off 1", n_init, init_off); end
    n_checks++; if (n_done !== 1 || n_done_last !== 1) begin
      n_errors++; $display("FAIL basic_done: got %0d/%0d expected 1/1", n_done, n_done_last); end
    n_checks++; if (done_cyc !== 3) begin n_errors++; $display("FAIL basic_latency: got %0d expected 3", done_cyc); end
    n_checks++; if (n_sh !== 2) begin n_errors++; $display("FAIL basic_s_count: got %0d expected 2", n_sh); end
  endtask

  task automatic test_single_byte();
    src_words[0] = 32'h000000A5; src_words[1] = 32'hFFFFFFFF;
    exp_q.delete();
    exp_q.push_back({1'b1, 4'b0001, 32'h000000A5});
    send_cmd(2'd3, 16'd1);
    run_xfer(2, 0, 40);
    n_checks++; if (got_q.size() !== 1) begin n_errors++; $display("FAIL single_nbeats: got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_checks++; if (got_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL single_beat: got %h expected %h", got_q[0], exp_q[0]); end
    end
    n_checks++; if (n_sh !== 1) begin n_errors++; $display("FAIL single_s_count: got %0d expected 1", n_sh); end
    n_checks++; if (init_off !== 2'd3) begin n_errors++; $display("FAIL single_offset: got %0d expected 3", init_off); end
  endtask

  task automatic test_backpressure();
    src_words[0] = 32'h11223344; src_words[1] = 32'h55667788; src_words[2] = 32'h99AABBCC;
    exp_q.delete();
    exp_q.push_back({1'b0, 4'b1111, 32'h11223344});
    exp_q.push_back({1'b1, 4'b1111, 32'h55667788});
    send_cmd(2'd0, 16'd8);
    run_xfer(3, 1, 40);
    n_checks++; if (got_q.size() !== 2) begin n_errors++; $display("FAIL bp_nbeats: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL bp_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (n_stall_bad !== 0) begin n_errors++; $display("FAIL bp_stall_stable: got %0d changes expected 0", n_stall_bad); end
    n_checks++; if (n_sh !== 2) begin n_errors++; $display("FAIL bp_s_count: got %0d expected 2", n_sh); end
  endtask

  task automatic test_zero_len();
    src_words[0] = 32'hDEADBEEF; src_words[1] = 32'hFEEDFACE;
    send_cmd(2'd2, 16'd0);
    run_xfer(2, 0, 20);
    n_checks++; if (n_done !== 1 || done_cyc !== 0) begin
      n_errors++; $display("FAIL zero_done: got %0d pulses at cycle %0d expected 1 at 0", n_done, done_cyc); end
    n_checks++; if (n_init !== 0) begin n_errors++; $display("FAIL zero_rl_init: got %0d expected 0", n_init); end
    n_checks++; if (n_mv_seen !== 0) begin n_errors++; $display("FAIL zero_m_tvalid: got %0d expected 0", n_mv_seen); end
    n_checks++; if (n_st_seen !== 0) begin n_errors++; $display("FAIL zero_s_tready: got %0d expected 0", n_st_seen); end
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    src_words[0] = 32'hA1A2A3A4;
    send_cmd(2'd0, 16'd4);
    rl_idle = 1'b0;
    run_xfer(1, 0, 40);
    cmd_addr = 2'd2; cmd_len = 16'd5; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      if (cmd_ready) bad++;
      @(posedge aclk); #1;
    end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL b2b_cmd_ready_gated: got %0d ready cycles expected 0", bad); end
    rl_idle = 1'b1;
    src_words[0] = 32'h0000C0DE; src_words[1] = 32'hB0B1B200;
    exp_q.delete();
    exp_q.push_back({1'b0, 4'b0011, 32'h0000C0DE});
    exp_q.push_back({1'b1, 4'b1110, 32'hB0B1B200});
    send_cmd(2'd2, 16'd5);
    run_xfer(2, 0, 40);
    n_checks++; if (got_q.size() !== 2) begin n_errors++; $display("FAIL b2b_nbeats: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL b2b_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (init_off !== 2'd2) begin n_errors++; $display("FAIL b2b_offset: got %0d expected 2", init_off); end
  endtask

  task automatic test_reset_mid_packet();
    int cnt, k;
    cnt = 0; k = 0;
    send_cmd(2'd2, 16'd14);
    s_tvalid = 1'b1; m_tready = 1'b1;
    while (cnt < 2 && k < 20) begin
      s_tdata = 32'hA0000000 + cnt;
      @(negedge aclk);
      if (s_tvalid && s_tready) cnt++;
      @(posedge aclk); #1;
      k++;
    end
    n_checks++; if ({m_tvalid, m_tkeep, m_tdata} !== {1'b1, 4'b1111, 32'hA0000001}) begin
      n_errors++; $display("FAIL rmid_pre_beat2: got %h expected 1fa0000001", {m_tvalid, m_tkeep, m_tdata}); end
    #2;
    aresetn = 1'b0; s_tvalid = 1'b0;
    #1;
    n_checks++; if ({cmd_ready, s_tready, m_tvalid, m_tlast, rl_init, done} !== 6'b0) begin
      n_errors++; $display("FAIL rmid_ctrl: got %b expected 000000", {cmd_ready, s_tready, m_tvalid, m_tlast, rl_init, done}); end
    n_checks++; if ({m_tkeep, rl_offset} !== 6'b0) begin
      n_errors++; $display("FAIL rmid_keep_off: got %b expected 000000", {m_tkeep, rl_offset}); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    src_words[0] = 32'hCAFEF00D;
    exp_q.delete();
    exp_q.push_back({1'b1, 4'b1111, 32'hCAFEF00D});
    send_cmd(2'd0, 16'd4);
    run_xfer(1, 0, 40);
    n_checks++; if (got_q.size() !== 1) begin n_errors++; $display("FAIL rmid_nbeats: got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_checks++; if (got_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL rmid_beat: got %h expected %h", got_q[0], exp_q[0]); end
    end
    n_checks++; if (n_timeout !== 0) begin n_errors++; $display("FAIL final_timeout: got %0d expected 0", n_timeout); end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; n_timeout = 0;
    for (int i = 0; i < 8; i++) src_words[i] = 32'h0;
    test_reset();
    test_basic();
    test_single_byte();
    test_backpressure();
    test_zero_len();
    test_back_to_back();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
